latch_bank: RTL and testbench

//  Parametrised multi-channel successor to the single-bit enable latch: CHANNELS lanes of WIDTH bits.

---
 rtl/latch_bank_pkg.sv | 27 ++
 rtl/latch_bank_chan.sv | 64 ++++++
 rtl/latch_bank.sv | 107 ++++++++++
 tb/tb_latch_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types for latch_bank: lane mode and snapshot FSM encodings.
// The mode decoder folds the reserved encoding into FREEZE so the lanes never see it.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        MODE_TRANSP  = 2'b00,
        MODE_CAPTURE = 2'b01,
        MODE_FREEZE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_FULL = 1'b1
    } snap_state_e;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b00:   m = MODE_TRANSP;
            2'b01:   m = MODE_CAPTURE;
            default: m = MODE_FREEZE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One lane of latch_bank: flop-backed hold register, transparent bypass mux,
// and a saturating counter of value-changing writes.
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode_q,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] hold,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic             write_en;
    logic             changed;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        write_en = en && (mode_q == MODE_TRANSP || mode_q == MODE_CAPTURE);
        changed  = write_en && (d != hold_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= RESET_VAL;
        end else if (write_en) begin
            hold_q <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (changed && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Zero-latency bypass emulates the level-sensitive latch without a real latch.
    always_comb begin
        q = hold_q;
        if (mode_q == MODE_TRANSP && en) begin
            q = d;
        end
    end

    assign hold = hold_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/latch_bank.sv
// Multi-lane hold-register bank with global mode, per-lane change counters
// and a single-entry snapshot buffer with valid/ready handshake.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       enable,
    output logic [CHANNELS*WIDTH-1:0] Q,
    input  logic                      snap_req,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [CHANNELS*WIDTH-1:0] snap_data,
    output logic                      snap_overrun,
    input  logic                      clr_overrun,
    output logic [CHANNELS*CNT_W-1:0] chg_cnt,
    input  logic                      clr_cnt
);

    mode_e                     mode_q;
    logic [CHANNELS*WIDTH-1:0] hold_all;
    logic [CHANNELS*WIDTH-1:0] snap_data_q;
    snap_state_e               snap_state_q;
    snap_state_e               snap_state_d;
    logic                      snap_load;
    logic                      overrun_set;
    logic                      overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_FREEZE;
        end else begin
            mode_q <= decode_mode(mode);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        latch_bank_chan #(
            .WIDTH     (WIDTH),
            .CNT_W     (CNT_W),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .mode_q  (mode_q),
            .d       (D[i*WIDTH +: WIDTH]),
            .en      (enable[i]),
            .clr_cnt (clr_cnt),
            .q       (Q[i*WIDTH +: WIDTH]),
            .hold    (hold_all[i*WIDTH +: WIDTH]),
            .cnt     (chg_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_state_q <= SNAP_IDLE;
        end else begin
            snap_state_q <= snap_state_d;
        end
    end

    always_comb begin
        snap_state_d = snap_state_q;
        case (snap_state_q)
            SNAP_IDLE: if (snap_req) snap_state_d = SNAP_FULL;
            SNAP_FULL: if (snap_ready && !snap_req) snap_state_d = SNAP_IDLE;
            default:   snap_state_d = SNAP_IDLE;
        endcase
    end

    // A request is only accepted when the buffer is empty or being drained this cycle.
    always_comb begin
        snap_valid  = (snap_state_q == SNAP_FULL);
        snap_load   = snap_req && ((snap_state_q == SNAP_IDLE) || snap_ready);
        overrun_set = snap_req && (snap_state_q == SNAP_FULL) && !snap_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data_q <= '0;
        end else if (snap_load) begin
            snap_data_q <= hold_all;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (overrun_set) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign snap_data    = snap_data_q;
    assign snap_overrun = overrun_q;

endmodule

// File: tb/tb_latch_bank.sv
// Directed self-checking bench for latch_bank with default parameters
// (4 lanes x 8 bits, 4-bit counters, reset value 0).
module tb_latch_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                mode;
    logic [CHANNELS*WIDTH-1:0] D;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS*WIDTH-1:0] Q;
    logic                      snap_req;
    logic                      snap_valid;
    logic                      snap_ready;
    logic [CHANNELS*WIDTH-1:0] snap_data;
    logic                      snap_overrun;
    logic                      clr_overrun;
    logic [CHANNELS*CNT_W-1:0] chg_cnt;
    logic                      clr_cnt;

    int checks = 0;
    int errors = 0;

    latch_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .RESET_VAL('0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .D            (D),
        .enable       (enable),
        .Q            (Q),
        .snap_req     (snap_req),
        .snap_valid   (snap_valid),
        .snap_ready   (snap_ready),
        .snap_data    (snap_data),
        .snap_overrun (snap_overrun),
        .clr_overrun  (clr_overrun),
        .chg_cnt      (chg_cnt),
        .clr_cnt      (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        mode        = 2'b10;
        D           = '0;
        enable      = '0;
        snap_req    = 1'b0;
        snap_ready  = 1'b0;
        clr_overrun = 1'b0;
        clr_cnt     = 1'b0;
        tick();
        tick();
        check("reset_q", Q, 32'h0);
        check("reset_valid", {31'b0, snap_valid}, 32'h0);
        check("reset_cnt", {16'b0, chg_cnt}, 32'h0);
        check("reset_overrun", {31'b0, snap_overrun}, 32'h0);
        rst = 1'b0;
        tick();

        // TRANSPARENT: bypass is immediate, enable low holds last written value
        mode = 2'b00;
        tick();
        enable = 4'b0001;
        D[7:0] = 8'h5A;
        #1;
        check("transp_bypass", {24'b0, Q[7:0]}, 32'h5A);
        tick();
        enable = 4'b0000;
        D[7:0] = 8'h11;
        #1;
        check("transp_hold", {24'b0, Q[7:0]}, 32'h5A);
        check("transp_cnt0", {28'b0, chg_cnt[3:0]}, 32'h1);

        // CAPTURE: one-cycle latency; FREEZE ignores enable
        mode = 2'b01;
        tick();
        enable  = 4'b0010;
        D[15:8] = 8'h3C;
        #1;
        check("capture_old", {24'b0, Q[15:8]}, 32'h00);
        check("capture_q0", {24'b0, Q[7:0]}, 32'h5A);
        tick();
        check("capture_new", {24'b0, Q[15:8]}, 32'h3C);
        mode   = 2'b10;
        enable = 4'b0000;
        tick();
        enable  = 4'b0010;
        D[15:8] = 8'hFF;
        #1;
        check("freeze_comb", {24'b0, Q[15:8]}, 32'h3C);
        tick();
        check("freeze_edge", {24'b0, Q[15:8]}, 32'h3C);
        check("freeze_cnt1", {28'b0, chg_cnt[7:4]}, 32'h1);

        // Reserved mode behaves as FREEZE
        mode = 2'b11;
        tick();
        tick();
        check("rsvd_freeze", {24'b0, Q[15:8]}, 32'h3C);

        // Change counter on lane 2: 20 alternating writes saturate at 15
        mode   = 2'b01;
        enable = 4'b0000;
        tick();
        enable = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            D[23:16] = (k % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            if (k == 9) check("cnt_mid", {28'b0, chg_cnt[11:8]}, 32'hA);
        end
        check("cnt_sat", {28'b0, chg_cnt[11:8]}, 32'hF);
        D[23:16] = 8'h00;
        tick();
        check("cnt_same_sat", {28'b0, chg_cnt[11:8]}, 32'hF);
        clr_cnt  = 1'b1;
        D[23:16] = 8'h05;
        tick();
        clr_cnt = 1'b0;
        check("cnt_clr_wins", {16'b0, chg_cnt}, 32'h0);
        check("cnt_clr_hold", {24'b0, Q[23:16]}, 32'h05);
        tick();
        check("cnt_no_change", {28'b0, chg_cnt[11:8]}, 32'h0);
        D[23:16] = 8'h06;
        tick();
        check("cnt_change", {28'b0, chg_cnt[11:8]}, 32'h1);

        // Snapshot and overrun
        enable = 4'b1111;
        D      = 32'h0403_0201;
        tick();
        enable = 4'b0000;
        check("hold_loaded", Q, 32'h0403_0201);
        snap_req = 1'b1;
        #1;
        check("snap_valid_pre", {31'b0, snap_valid}, 32'h0);
        tick();
        snap_req = 1'b0;
        check("snap_valid", {31'b0, snap_valid}, 32'h1);
        check("snap_data", snap_data, 32'h0403_0201);
        enable = 4'b1111;
        D      = 32'hAAAA_AAAA;
        tick();
        enable   = 4'b0000;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("overrun_set", {31'b0, snap_overrun}, 32'h1);
        check("overrun_data", snap_data, 32'h0403_0201);
        check("overrun_valid", {31'b0, snap_valid}, 32'h1);
        tick();
        check("overrun_sticky", {31'b0, snap_overrun}, 32'h1);
        clr_overrun = 1'b1;
        snap_req    = 1'b1;
        tick();
        snap_req = 1'b0;
        check("overrun_set_wins", {31'b0, snap_overrun}, 32'h1);
        tick();
        clr_overrun = 1'b0;
        check("overrun_clr", {31'b0, snap_overrun}, 32'h0);

        // Back-to-back: drain and reload in the same cycle
        snap_ready = 1'b1;
        snap_req   = 1'b1;
        tick();
        snap_req = 1'b0;
        check("b2b_valid", {31'b0, snap_valid}, 32'h1);
        check("b2b_data", snap_data, 32'hAAAA_AAAA);
        check("b2b_overrun", {31'b0, snap_overrun}, 32'h0);
        tick();
        snap_ready = 1'b0;
        check("drain_valid", {31'b0, snap_valid}, 32'h0);
        check("drain_data", snap_data, 32'hAAAA_AAAA);

        // Asynchronous reset mid-traffic
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("pre_rst_valid", {31'b0, snap_valid}, 32'h1);
        mode   = 2'b00;
        enable = 4'b1111;
        D      = 32'h1234_5678;
        rst    = 1'b1;
        #1;
        check("async_rst_q", Q, 32'h0);
        check("async_rst_valid", {31'b0, snap_valid}, 32'h0);
        check("async_rst_cnt", {16'b0, chg_cnt}, 32'h0);
        check("async_rst_data", snap_data, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_freeze", Q, 32'h0);
        tick();
        check("post_rst_transp", Q, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
